// File: rtl/i2c_pkg.sv
// Shared types and widths for the i2c request arbiter.
//   state_t : arbiter sequencer states
//   hold_t  : transfer fields latched from the granted requester
package i2c_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wr;
    } hold_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : index where the search starts (wraps modulo NREQ)
//   gnt   : one-hot winner, 0 when nothing is requested
//   idx   : binary index of the winner
//   found : a winner exists
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    found
);

    localparam int IW = $clog2(NREQ);

    always_comb begin : pick
        logic [IW-1:0] pos;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[pos]) begin
                found    = 1'b1;
                idx      = pos;
                gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter and transfer sequencer sharing one i2c master engine.
//   clk, rst (async, active-low)
//   req/req_addr/req_data/req_wr : per-requester transfer posts (packed slices)
//   ack/rsp_data/rsp_err         : one-cycle completion strobe with read data / timeout flag
//   grant                        : one-hot current owner
//   eng_en/eng_maddr/eng_data/eng_wr : engine command, eng_done/eng_rdata : engine completion
// Every output is a register; nothing is combinational from an input.
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_wr,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic [NREQ-1:0]        grant,
    output logic                   eng_en,
    output logic [ADDR_W-1:0]      eng_maddr,
    output logic [DATA_W-1:0]      eng_data,
    output logic                   eng_wr,
    input  logic                   eng_done,
    input  logic [DATA_W-1:0]      eng_rdata
);

    localparam int IW = $clog2(NREQ);
    // Last counter value of the wait window: the window is TIMEOUT cycles
    // long, so the abort is decided when the counter is about to reach TIMEOUT.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_a[i] = req_data[i*DATA_W +: DATA_W];
    end

    state_t            state, state_nxt;
    logic [IW-1:0]     ptr, ptr_nxt;
    logic [IW-1:0]     idx_q, idx_nxt;
    hold_t             hold, hold_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic [NREQ-1:0]   grant_nxt, ack_nxt;
    logic [NREQ-1:0]   last_gnt, last_nxt;
    logic [DATA_W-1:0] rsp_data_nxt;
    logic              rsp_err_nxt, eng_en_nxt;

    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_found;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign eng_maddr = hold.addr;
    assign eng_data  = hold.data;
    assign eng_wr    = hold.wr;

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        idx_nxt      = idx_q;
        hold_nxt     = hold;
        cnt_nxt      = cnt;
        grant_nxt    = grant;
        ack_nxt      = '0;
        last_nxt     = last_gnt;
        rsp_data_nxt = rsp_data;
        rsp_err_nxt  = rsp_err;
        eng_en_nxt   = eng_en;
        case (state)
            IDLE: begin
                // The requester just served may still hold req in this cycle.
                last_nxt = '0;
                if (|(req & ~last_gnt)) state_nxt = GRANT;
            end
            GRANT: begin
                if (pick_found) begin
                    grant_nxt     = pick_gnt;
                    idx_nxt       = pick_idx;
                    hold_nxt.addr = addr_a[pick_idx];
                    hold_nxt.data = data_a[pick_idx];
                    hold_nxt.wr   = req_wr[pick_idx];
                    state_nxt     = ISSUE;
                end else begin
                    // Request withdrawn before it could be granted.
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                eng_en_nxt = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + 16'd1;
                if (eng_done) begin
                    rsp_data_nxt = eng_rdata;
                    rsp_err_nxt  = 1'b0;
                    ack_nxt      = grant;
                    eng_en_nxt   = 1'b0;
                    state_nxt    = RESP;
                end else if (cnt == TO_LAST) begin
                    rsp_data_nxt = '0;
                    rsp_err_nxt  = 1'b1;
                    ack_nxt      = grant;
                    eng_en_nxt   = 1'b0;
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                ptr_nxt   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                last_nxt  = grant;
                grant_nxt = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            idx_q    <= '0;
            hold     <= '0;
            cnt      <= '0;
            grant    <= '0;
            ack      <= '0;
            last_gnt <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            eng_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            idx_q    <= idx_nxt;
            hold     <= hold_nxt;
            cnt      <= cnt_nxt;
            grant    <= grant_nxt;
            ack      <= ack_nxt;
            last_gnt <= last_nxt;
            rsp_data <= rsp_data_nxt;
            rsp_err  <= rsp_err_nxt;
            eng_en   <= eng_en_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin model.
module tb_i2c_req_arbiter;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance (TIMEOUT default)
    logic [NREQ-1:0]   req = '0, req_wr = '0, ack, grant;
    logic [3*NREQ-1:0] req_addr = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [7:0]        rsp_data, eng_data;
    logic [7:0]        eng_rdata = '0;
    logic              rsp_err, eng_en, eng_wr;
    logic              eng_done = 1'b0;
    logic [2:0]        eng_maddr;

    // short-timeout instance
    logic [NREQ-1:0]   req_t = '0, req_wr_t = '0, ack_t, grant_t;
    logic [3*NREQ-1:0] req_addr_t = '0;
    logic [8*NREQ-1:0] req_data_t = '0;
    logic [7:0]        rsp_data_t, eng_data_t;
    logic [7:0]        eng_rdata_t = '0;
    logic              rsp_err_t, eng_en_t, eng_wr_t;
    logic              eng_done_t = 1'b0;
    logic [2:0]        eng_maddr_t;

    int checks = 0;
    int failures = 0;

    logic [2:0] fa [NREQ];
    logic [7:0] fd [NREQ];
    logic       fw [NREQ];

    i2c_req_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .req_wr(req_wr), .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .grant(grant),
        .eng_en(eng_en), .eng_maddr(eng_maddr), .eng_data(eng_data), .eng_wr(eng_wr),
        .eng_done(eng_done), .eng_rdata(eng_rdata)
    );

    i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(15)) dut_to (
        .clk(clk), .rst(rst), .req(req_t), .req_addr(req_addr_t), .req_data(req_data_t),
        .req_wr(req_wr_t), .ack(ack_t), .rsp_data(rsp_data_t), .rsp_err(rsp_err_t), .grant(grant_t),
        .eng_en(eng_en_t), .eng_maddr(eng_maddr_t), .eng_data(eng_data_t), .eng_wr(eng_wr_t),
        .eng_done(eng_done_t), .eng_rdata(eng_rdata_t)
    );

    // Reference: first requester at or after 'from', wrapping.
    function automatic int rr_winner(input logic [NREQ-1:0] p, input int from);
        for (int k = 0; k < NREQ; k++)
            if (p[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    task automatic post(input int i, input logic [2:0] a, input logic [7:0] d, input logic w);
        req_addr[i*3 +: 3] = a;
        req_data[i*8 +: 8] = d;
        req_wr[i]          = w;
        req[i]             = 1'b1;
    endtask

    task automatic wait_grant(input bit sel, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if ((sel ? grant_t : grant) !== '0) ok = 1'b1;
        end
    endtask

    // From the ISSUE cycle: raise eng_done in the lat-th enabled cycle and
    // return in the ack cycle.
    task automatic finish_xfer(input int lat, input logic [7:0] rd);
        @(negedge clk);
        repeat (lat - 1) @(negedge clk);
        eng_done  = 1'b1;
        eng_rdata = rd;
        @(negedge clk);
        eng_done  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, grant, rsp_data, rsp_err, eng_en, eng_maddr, eng_data, eng_wr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0",
                     {ack, grant, rsp_data, rsp_err, eng_en, eng_maddr, eng_data, eng_wr});
        end
        checks++;
        if ({ack_t, grant_t, rsp_data_t, rsp_err_t, eng_en_t, eng_maddr_t, eng_data_t, eng_wr_t} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_to: got %h required 0",
                     {ack_t, grant_t, rsp_data_t, rsp_err_t, eng_en_t, eng_maddr_t, eng_data_t, eng_wr_t});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        bit stable;
        post(1, 3'b101, 8'h81, 1'b1);        // cycle 0 (IDLE)
        @(negedge clk);                      // GRANT
        @(negedge clk);                      // ISSUE
        checks++;
        if (grant !== 4'b0010 || eng_en !== 1'b0) begin
            failures++;
            $display("FAIL write_grant: grant=%b eng_en=%b required 0010/0", grant, eng_en);
        end
        @(negedge clk);
        checks++;
        if (eng_en !== 1'b1) begin
            failures++;
            $display("FAIL write_en_latency: eng_en=%b required 1 three cycles after req", eng_en);
        end
        stable = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (eng_en !== 1'b1 || eng_maddr !== 3'd5 || eng_data !== 8'h81 || eng_wr !== 1'b1 || ack !== '0)
                stable = 1'b0;
            if (n == 39) begin
                eng_done  = 1'b1;
                eng_rdata = 8'h3c;
            end
            @(negedge clk);
        end
        eng_done = 1'b0;
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL write_fields_stable: got unstable required addr=5 data=81 wr=1 for 40 cycles");
        end
        checks++;
        if (ack !== 4'b0010 || rsp_err !== 1'b0 || eng_en !== 1'b0 || rsp_data !== 8'h3c) begin
            failures++;
            $display("FAIL write_ack: ack=%b err=%b en=%b data=%h required 0010/0/0/3c",
                     ack, rsp_err, eng_en, rsp_data);
        end
        req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== '0 || grant !== '0) begin
            failures++;
            $display("FAIL write_ack_pulse: ack=%b grant=%b required 0000/0000", ack, grant);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] expg, prev;
        logic [7:0] rd;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) post(i, 3'(i), 8'(8'h10 + i), 1'b0);
        prev = '0;
        for (int k = 0; k < 5; k++) begin
            expg = 4'b0001 << (k % 4);
            wait_grant(1'b0, ok);
            checks++;
            if (!ok || grant !== expg || grant === prev) begin
                failures++;
                $display("FAIL rr_order_%0d: grant=%b required %b", k, grant, expg);
            end
            prev = grant;
            rd = 8'($urandom);
            finish_xfer(int'($urandom_range(1, 5)), rd);
            checks++;
            if (ack !== expg || rsp_data !== rd) begin
                failures++;
                $display("FAIL rr_ack_%0d: ack=%b data=%h required %b/%h", k, ack, rsp_data, expg, rd);
            end
            if (k == 4) req = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_read();
        bit ok;
        post(2, 3'b111, 8'h00, 1'b0);
        wait_grant(1'b0, ok);
        checks++;
        if (!ok || grant !== 4'b0100) begin
            failures++;
            $display("FAIL read_grant: grant=%b required 0100", grant);
        end
        finish_xfer(7, 8'hc6);
        checks++;
        if (ack !== 4'b0100 || rsp_data !== 8'hc6 || rsp_err !== 1'b0 || eng_maddr !== 3'd7 || eng_wr !== 1'b0) begin
            failures++;
            $display("FAIL read_ack: ack=%b data=%h err=%b addr=%0d wr=%b required 0100/c6/0/7/0",
                     ack, rsp_data, rsp_err, eng_maddr, eng_wr);
        end
        req[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok, quiet;
        for (int pass = 0; pass < 2; pass++) begin
            req_addr_t[2:0] = 3'd4;
            req_data_t[7:0] = 8'h99;
            req_wr_t[0]     = 1'b0;
            req_t[0]        = 1'b1;
            wait_grant(1'b1, ok);              // ISSUE cycle c
            checks++;
            if (!ok || grant_t !== 4'b0001) begin
                failures++;
                $display("FAIL timeout_grant_%0d: grant=%b required 0001", pass, grant_t);
            end
            quiet = 1'b1;
            for (int n = 1; n <= 15; n++) begin
                @(negedge clk);                // cycle c+n
                if (ack_t !== '0 || eng_en_t !== 1'b1) quiet = 1'b0;
                if (pass == 0 && n == 15) begin
                    eng_done_t  = 1'b1;
                    eng_rdata_t = 8'h5a;
                end
            end
            @(negedge clk);                    // cycle c+16
            eng_done_t = 1'b0;
            checks++;
            if (!quiet) begin
                failures++;
                $display("FAIL timeout_window_%0d: early ack or eng_en drop, required 15 enabled cycles", pass);
            end
            checks++;
            if (pass == 0) begin
                if (ack_t !== 4'b0001 || rsp_err_t !== 1'b0 || rsp_data_t !== 8'h5a) begin
                    failures++;
                    $display("FAIL timeout_done_wins: ack=%b err=%b data=%h required 0001/0/5a",
                             ack_t, rsp_err_t, rsp_data_t);
                end
            end else begin
                if (ack_t !== 4'b0001 || rsp_err_t !== 1'b1 || rsp_data_t !== 8'h00 || eng_en_t !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_abort: ack=%b err=%b data=%h en=%b required 0001/1/00/0",
                             ack_t, rsp_err_t, rsp_data_t, eng_en_t);
                end
            end
            req_t[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, no_ack;
        logic [3:0] order [3];
        order[0] = 4'b0001;
        order[1] = 4'b0100;
        order[2] = 4'b1000;
        post(1, 3'd1, 8'h11, 1'b1);
        wait_grant(1'b0, ok);
        finish_xfer(2, 8'h00);
        req[1] = 1'b0;
        post(2, 3'd2, 8'h22, 1'b1);
        wait_grant(1'b0, ok);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (eng_en !== 1'b0 || grant !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: eng_en=%b grant=%b required 0/0000 before any edge", eng_en, grant);
        end
        no_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (ack !== '0) no_ack = 1'b0;
        end
        rst = 1'b1;
        post(0, 3'd3, 8'h33, 1'b0);
        post(3, 3'd6, 8'h66, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_grant(1'b0, ok);
            checks++;
            if (!ok || grant !== order[k]) begin
                failures++;
                $display("FAIL reset_mid_order_%0d: grant=%b required %b", k, grant, order[k]);
            end
            @(negedge clk);
            if (ack !== '0) no_ack = 1'b0;
            finish_xfer(2, 8'h44);
            checks++;
            if (ack !== order[k]) begin
                failures++;
                $display("FAIL reset_mid_ack_%0d: ack=%b required %b", k, ack, order[k]);
            end
            req = req & ~order[k];
        end
        checks++;
        if (!no_ack) begin
            failures++;
            $display("FAIL reset_mid_no_ack: an ack appeared for the aborted transfer, required none");
        end
        @(negedge clk);
    endtask

    task automatic test_field_change();
        bit ok, stable;
        post(3, 3'd2, 8'ha5, 1'b1);
        wait_grant(1'b0, ok);
        @(negedge clk);
        req_addr[11:9] = 3'd6;
        req_data[31:24] = 8'h5a;
        req_wr[3] = 1'b0;
        stable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (eng_data !== 8'ha5 || eng_maddr !== 3'd2 || eng_wr !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!ok || !stable) begin
            failures++;
            $display("FAIL field_change: data=%h addr=%0d wr=%b required a5/2/1", eng_data, eng_maddr, eng_wr);
        end
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        checks++;
        if (ack !== 4'b1000) begin
            failures++;
            $display("FAIL field_change_ack: ack=%b required 1000", ack);
        end
        req[3] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ok;
        logic [NREQ-1:0] pend, newr;
        int ptr_m, exp_i, lat;
        logic [7:0] rd;
        logic [3:0] expg;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        pend = '0;
        ptr_m = 0;
        for (int r = 0; r < 30; r++) begin
            newr = 4'($urandom_range(0, 15));
            if ((pend | newr) == '0) newr = 4'b0001 << $urandom_range(0, 3);
            for (int i = 0; i < NREQ; i++) begin
                if (newr[i] && !pend[i]) begin
                    fa[i] = 3'($urandom);
                    fd[i] = 8'($urandom);
                    fw[i] = 1'($urandom);
                    post(i, fa[i], fd[i], fw[i]);
                    pend[i] = 1'b1;
                end
            end
            exp_i = rr_winner(pend, ptr_m);
            expg = 4'b0001 << exp_i;
            wait_grant(1'b0, ok);
            checks++;
            if (!ok || grant !== expg) begin
                failures++;
                $display("FAIL rand_grant_%0d: grant=%b required %b", r, grant, expg);
            end
            @(negedge clk);
            checks++;
            if (eng_en !== 1'b1 || eng_maddr !== fa[exp_i] || eng_data !== fd[exp_i] || eng_wr !== fw[exp_i]) begin
                failures++;
                $display("FAIL rand_fields_%0d: en=%b addr=%0d data=%h wr=%b required 1/%0d/%h/%b",
                         r, eng_en, eng_maddr, eng_data, eng_wr, fa[exp_i], fd[exp_i], fw[exp_i]);
            end
            req_data[exp_i*8 +: 8] = 8'($urandom);
            lat = int'($urandom_range(1, 12));
            rd = 8'($urandom);
            repeat (lat - 1) @(negedge clk);
            eng_done = 1'b1;
            eng_rdata = rd;
            @(negedge clk);
            eng_done = 1'b0;
            checks++;
            if (ack !== expg || rsp_data !== rd || rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL rand_ack_%0d: ack=%b data=%h err=%b required %b/%h/0",
                         r, ack, rsp_data, rsp_err, expg, rd);
            end
            req[exp_i] = 1'b0;
            pend[exp_i] = 1'b0;
            ptr_m = (exp_i + 1) % NREQ;
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read();
        test_timeout();
        test_reset_mid();
        test_field_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
